bcd4221_to_8421_seq: RTL and testbench

Iterative multi-digit converter from decimal 4221 code back to 8421 BCD. It is the inverse of the per-digit 8421→4221 recoding used on the multiplier input side: it sits at the output of the parallel decimal multiplier, after partial-product reduction, and turns a DIGITS-wide 4221 word into BCD. It converts DPC digits per cycle and uses a valid/ready handshake on both sides. It also flags any digit that is not in the canonical encoding produced by the forward recoder.

---
 rtl/bcd4221_to_8421_seq_if.sv | 27 ++
 rtl/bcd4221_to_8421_seq.sv | 118 +++++++++++
 tb/tb_bcd4221_to_8421_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd4221_to_8421_seq_if.sv
// Handshake/data bundle for bcd4221_to_8421_seq.
//   in_valid, in_ready, in_x4221    : input word channel (4221 code, digit i at [4i+3:4i])
//   out_valid, out_ready, out_bcd,
//   out_noncanon                    : result channel (8421 BCD plus non-canonical flag)
// Modport slave is the converter's view; modport master is the view of the
// agent that drives words in and consumes results.
interface bcd4221_to_8421_seq_if #(
    parameter int unsigned DIGITS = 16
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_x4221;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_noncanon;

    modport slave (
        input  in_valid, in_x4221, out_ready,
        output in_ready, out_valid, out_bcd, out_noncanon
    );

    modport master (
        output in_valid, in_x4221, out_ready,
        input  in_ready, out_valid, out_bcd, out_noncanon
    );
endinterface

// File: rtl/bcd4221_to_8421_seq.sv
// Iterative 4221-to-8421 BCD converter, DPC digits per cycle, DIGITS/DPC
// cycles per word, valid/ready on both sides. Flags any digit not in the
// canonical set produced by the forward 8421->4221 recoder.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave modport of bcd4221_to_8421_seq_if (input word / result channels)
//   busy   : high whenever the FSM is not idle
module bcd4221_to_8421_seq #(
    parameter int unsigned DIGITS = 16,
    parameter int unsigned DPC    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    bcd4221_to_8421_seq_if.slave          bus,
    output logic                          busy
);
    localparam int unsigned N  = DIGITS / DPC;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state_q, state_nx;
    logic [CW-1:0]         cnt_q;
    logic [4*DIGITS-1:0]   src_q;
    logic [4*DIGITS-1:0]   res_q;
    logic                  flag_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic                  nc_q;

    logic [4*DPC-1:0]      conv;
    logic                  nc_any;
    logic [3:0]            code;
    logic [4*DIGITS-1:0]   conv_w;
    logic [4*DIGITS-1:0]   res_nx;
    logic                  flag_nx;
    logic                  last;

    // Per-digit recode of the lowest DPC source digits.
    // Non-canonical means b2 set without the b3/b1 pair that the forward
    // recoder always emits alongside it (only 1110/1111 are legal with b2=1).
    always_comb begin
        conv   = '0;
        nc_any = 1'b0;
        code   = '0;
        for (int unsigned d = 0; d < DPC; d++) begin
            code = src_q[4*d +: 4];
            conv[4*d +: 4] = {1'b0, code[3], 2'b00}
                           + {2'b00, code[2], 1'b0}
                           + {2'b00, code[1], 1'b0}
                           + {3'b000, code[0]};
            nc_any = nc_any | (code[2] & ~(code[3] & code[1]));
        end
    end

    // Converted digits enter the result from the top; after N shifts digit 0
    // sits at the bottom. Written as shift/or so DPC == DIGITS needs no special case.
    always_comb begin
        conv_w              = '0;
        conv_w[4*DPC-1:0]   = conv;
        res_nx              = (res_q >> (4*DPC)) | (conv_w << (4*(DIGITS-DPC)));
        flag_nx             = flag_q | nc_any;
        last                = (cnt_q == CW'(N-1));
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_nx = CONV;
            CONV:    if (last)         state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            bcd_q   <= '0;
            nc_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        src_q  <= bus.in_x4221;
                        cnt_q  <= '0;
                        flag_q <= 1'b0;
                    end
                end
                CONV: begin
                    src_q  <= src_q >> (4*DPC);
                    res_q  <= res_nx;
                    flag_q <= flag_nx;
                    cnt_q  <= cnt_q + CW'(1);
                    // Outputs are loaded only on entry to DONE so they stay
                    // stable while the next word is shifting through res_q.
                    if (last) begin
                        bcd_q <= res_nx;
                        nc_q  <= flag_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.out_bcd      = bcd_q;
    assign bus.out_noncanon = nc_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_bcd4221_to_8421_seq.sv
// Directed self-checking bench for bcd4221_to_8421_seq.
// Three instances: defaults (16 digits, 4/cycle), 4 digits 2/cycle,
// 4 digits 1/cycle (exhaustive code sweep).
module tb_bcd4221_to_8421_seq;
    logic clk;
    logic rst_n;
    logic busy16, busy4b, busy4c;

    int checks = 0;
    int errors = 0;

    bcd4221_to_8421_seq_if #(.DIGITS(16)) if16 ();
    bcd4221_to_8421_seq_if #(.DIGITS(4))  if4b ();
    bcd4221_to_8421_seq_if #(.DIGITS(4))  if4c ();

    bcd4221_to_8421_seq #(.DIGITS(16), .DPC(4)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(if16.slave), .busy(busy16));
    bcd4221_to_8421_seq #(.DIGITS(4), .DPC(2)) u4b (
        .clk(clk), .rst_n(rst_n), .bus(if4b.slave), .busy(busy4b));
    bcd4221_to_8421_seq #(.DIGITS(4), .DPC(1)) u4c (
        .clk(clk), .rst_n(rst_n), .bus(if4c.slave), .busy(busy4c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference digit table: {noncanon, value} for each 4221 code.
    function automatic logic [4:0] ref4221(input logic [3:0] c);
        case (c)
            4'h0: return {1'b0, 4'd0};
            4'h1: return {1'b0, 4'd1};
            4'h2: return {1'b0, 4'd2};
            4'h3: return {1'b0, 4'd3};
            4'h4: return {1'b1, 4'd2};
            4'h5: return {1'b1, 4'd3};
            4'h6: return {1'b1, 4'd4};
            4'h7: return {1'b1, 4'd5};
            4'h8: return {1'b0, 4'd4};
            4'h9: return {1'b0, 4'd5};
            4'hA: return {1'b0, 4'd6};
            4'hB: return {1'b0, 4'd7};
            4'hC: return {1'b1, 4'd6};
            4'hD: return {1'b1, 4'd7};
            4'hE: return {1'b0, 4'd8};
            default: return {1'b0, 4'd9};
        endcase
    endfunction

    // One word through the DPC=2 instance; lat = edges from accept to out_valid.
    task automatic run4b(input logic [15:0] x, output logic [15:0] bcd,
                         output logic nc, output int lat);
        int w;
        w = 0;
        while (!if4b.in_ready && w < 20) begin @(posedge clk); #1; w++; end
        if4b.in_valid = 1'b1;
        if4b.in_x4221 = x;
        @(posedge clk); #1;
        if4b.in_valid = 1'b0;
        lat = 0;
        while (!if4b.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        bcd = if4b.out_bcd;
        nc  = if4b.out_noncanon;
    endtask

    task automatic run4c(input logic [15:0] x, output logic [15:0] bcd,
                         output logic nc, output int lat);
        int w;
        w = 0;
        while (!if4c.in_ready && w < 20) begin @(posedge clk); #1; w++; end
        if4c.in_valid = 1'b1;
        if4c.in_x4221 = x;
        @(posedge clk); #1;
        if4c.in_valid = 1'b0;
        lat = 0;
        while (!if4c.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        bcd = if4c.out_bcd;
        nc  = if4c.out_noncanon;
    endtask

    initial begin
        logic [15:0] b16;
        logic        nc;
        int          lat;
        logic [63:0] hold;
        logic [15:0] word;
        logic [15:0] exp_bcd;
        logic        exp_nc;
        logic [4:0]  r;
        int          seen;

        rst_n = 1'b0;
        if16.in_valid = 1'b0; if16.in_x4221 = '0; if16.out_ready = 1'b1;
        if4b.in_valid = 1'b0; if4b.in_x4221 = '0; if4b.out_ready = 1'b1;
        if4c.in_valid = 1'b0; if4c.in_x4221 = '0; if4c.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(if16.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if16.out_valid), 64'd0);
        chk("rst_out_bcd",   if16.out_bcd, 64'd0);
        chk("rst_noncanon",  64'(if16.out_noncanon), 64'd0);
        chk("rst_busy",      64'(busy16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- default instance: main word, exact latency and single-cycle valid
        @(negedge clk);
        if16.in_valid = 1'b1;
        if16.in_x4221 = 64'hFEBA_9832_10FE_BA98;
        @(posedge clk); #1;               // accept edge T
        if16.in_valid = 1'b0;
        chk("accept_busy", 64'(busy16), 64'd1);
        chk("accept_in_ready", 64'(if16.in_ready), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat16_cyc%0d", k), 64'(if16.out_valid), (k == 4) ? 64'd1 : 64'd0);
        end
        chk("main_bcd", if16.out_bcd, 64'h9876_5432_1098_7654);
        chk("main_nc",  64'(if16.out_noncanon), 64'd0);
        @(posedge clk); #1;
        chk("main_valid_drop", 64'(if16.out_valid), 64'd0);
        chk("main_ready_back", 64'(if16.in_ready), 64'd1);

        // ---- DPC=2: three words, flag is per word
        run4b(16'h4567, b16, nc, lat);
        chk("w4567_lat", 64'(lat), 64'd2);
        chk("w4567_bcd", 64'(b16), 64'h2345);
        chk("w4567_nc",  64'(nc), 64'd1);
        run4b(16'hCD00, b16, nc, lat);
        chk("wCD00_bcd", 64'(b16), 64'h6700);
        chk("wCD00_nc",  64'(nc), 64'd1);
        run4b(16'hFE10, b16, nc, lat);
        chk("wFE10_bcd", 64'(b16), 64'h9810);
        chk("wFE10_nc",  64'(nc), 64'd0);

        // ---- backpressure on DPC=2 instance
        @(posedge clk); #1;
        if4b.out_ready = 1'b0;
        run4b(16'h3210, b16, nc, lat);
        chk("bp_first_bcd", 64'(b16), 64'h3210);
        if4b.in_valid = 1'b1;
        if4b.in_x4221 = 16'h9898;        // 9->5, 8->4
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", k), 64'(if4b.out_valid), 64'd1);
            chk($sformatf("bp_bcd_%0d", k),   64'(if4b.out_bcd), 64'h3210);
            chk($sformatf("bp_ready_%0d", k), 64'(if4b.in_ready), 64'd0);
        end
        if4b.out_ready = 1'b1;
        @(posedge clk); #1;              // handshake edge
        chk("bp_after_valid", 64'(if4b.out_valid), 64'd0);
        chk("bp_after_ready", 64'(if4b.in_ready), 64'd1);
        chk("bp_after_busy",  64'(busy4b), 64'd0);
        @(posedge clk); #1;              // held word captured here
        if4b.in_valid = 1'b0;
        chk("bp_capture_busy", 64'(busy4b), 64'd1);
        lat = 0;
        while (!if4b.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp_second_lat", 64'(lat), 64'd2);
        chk("bp_second_bcd", 64'(if4b.out_bcd), 64'h5454);
        @(posedge clk); #1;

        // ---- asynchronous reset two cycles after an accept
        @(negedge clk);
        if16.in_valid = 1'b1;
        if16.in_x4221 = 64'h1111_1111_1111_1111;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  64'(if16.in_ready), 64'd1);
        chk("arst_out_valid", 64'(if16.out_valid), 64'd0);
        chk("arst_out_bcd",   if16.out_bcd, 64'd0);
        chk("arst_noncanon",  64'(if16.out_noncanon), 64'd0);
        chk("arst_busy",      64'(busy16), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (if16.out_valid) seen++;
        end
        chk("arst_no_valid", 64'(seen), 64'd0);
        @(negedge clk);
        if16.in_valid = 1'b1;
        if16.in_x4221 = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("post_rst_lat", 64'(lat), 64'd4);
        chk("post_rst_bcd", if16.out_bcd, 64'h0123_2345_4567_6789);
        chk("post_rst_nc",  64'(if16.out_noncanon), 64'd1);
        @(posedge clk); #1;

        // ---- DPC=1 sweep: every code in every position
        for (int k = 0; k < 16; k++) begin
            exp_bcd = '0;
            exp_nc  = 1'b0;
            for (int p = 0; p < 4; p++) begin
                word[4*p +: 4] = 4'((k + 5*p) % 16);
                r = ref4221(word[4*p +: 4]);
                exp_bcd[4*p +: 4] = r[3:0];
                exp_nc = exp_nc | r[4];
            end
            run4c(word, b16, nc, lat);
            chk($sformatf("sweep%0d_lat", k), 64'(lat), 64'd4);
            chk($sformatf("sweep%0d_bcd", k), 64'(b16), 64'(exp_bcd));
            chk($sformatf("sweep%0d_nc", k),  64'(nc), 64'(exp_nc));
        end
        // canonical-only word with all legal codes present in turn
        run4c(16'hFEBA, b16, nc, lat);
        chk("sweep_canon_bcd", 64'(b16), 64'h9876);
        chk("sweep_canon_nc",  64'(nc), 64'd0);

        hold = 64'(checks);
        $display("CHECKS %0d ERRORS %0d", hold, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
